// File: rtl/iot_in_packer_pkg.sv
// rtl/iot_in_packer_pkg.sv - shared IoT datapath definitions
package iot_in_packer_pkg;

  localparam int BYTES  = 16;
  localparam int DATA_W = 8 * BYTES;

  // Function-unit codes; the packer forwards them without decoding.
  typedef enum logic [2:0] {
    FnPass   = 3'd0,
    Bin2Gray = 3'd1,
    Gray2Bin = 3'd2,
    FnThresh = 3'd3,
    FnAvg    = 3'd4,
    FnMin    = 3'd5,
    FnMax    = 3'd6,
    FnCrc    = 3'd7
  } fn_code_e;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2
  } disp_state_e;

endpackage

// File: rtl/iot_byte_shifter.sv
// rtl/iot_byte_shifter.sv - byte-serial assembly of one word with its function code
module iot_byte_shifter #(
  parameter int BYTES = iot_in_packer_pkg::BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_en,
  input  logic [7:0]         iot_in,
  input  logic [2:0]         fn_sel,
  input  logic               busy,
  input  logic               xfer,
  output logic [8*BYTES-1:0] asm_data,
  output logic [2:0]         asm_fn,
  output logic               asm_full,
  output logic               overrun
);

  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0] byte_cnt;
  logic             accept;

  assign accept = in_en && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data <= '0;
      asm_fn   <= '0;
      asm_full <= 1'b0;
      byte_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= in_en && busy;
      if (xfer)
        asm_full <= 1'b0;
      // A byte may arrive in the transfer cycle; it starts the next word.
      if (accept) begin
        asm_data <= {asm_data[8*BYTES-9:0], iot_in};
        if (byte_cnt == '0)
          asm_fn <= fn_sel;
        if (byte_cnt == LAST) begin
          byte_cnt <= '0;
          asm_full <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iot_in_packer.sv
// rtl/iot_in_packer.sv - packs the sensor byte stream into words and dispatches them to the function units
module iot_in_packer
  import iot_in_packer_pkg::*;
#(
  parameter int BYTES     = iot_in_packer_pkg::BYTES,
  parameter int NUM_WORDS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_en,
  input  logic [7:0]         iot_in,
  input  logic [2:0]         fn_sel,
  input  logic               fu_valid,
  output logic               busy,
  output logic               fu_en,
  output logic [2:0]         fu_fn,
  output logic [8*BYTES-1:0] fu_data,
  output logic               overrun,
  output logic               done
);

  localparam int W    = 8 * BYTES;
  localparam int BC_W = $clog2(NUM_WORDS + 1);
  localparam logic [BC_W-1:0] BATCH_LAST = BC_W'(NUM_WORDS - 1);

  logic [W-1:0]    asm_data, pend_data;
  logic [2:0]      asm_fn, pend_fn;
  logic            asm_full, pend_valid;
  logic            clear_this_cycle, xfer;
  logic [BC_W-1:0] batch_cnt;
  disp_state_e     state;

  assign clear_this_cycle = (state == D_WAIT) && fu_valid;
  assign xfer             = asm_full && (!pend_valid || clear_this_cycle);
  // Stall the source only when a full word waits behind an occupied pending slot.
  assign busy             = asm_full && pend_valid;
  assign fu_data          = pend_data;
  assign fu_fn            = pend_fn;

  iot_byte_shifter #(.BYTES(BYTES)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .in_en    (in_en),
    .iot_in   (iot_in),
    .fn_sel   (fn_sel),
    .busy     (busy),
    .xfer     (xfer),
    .asm_data (asm_data),
    .asm_fn   (asm_fn),
    .asm_full (asm_full),
    .overrun  (overrun)
  );

  // A load in the same cycle as a clear wins, keeping pend_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data  <= '0;
      pend_fn    <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (clear_this_cycle)
        pend_valid <= 1'b0;
      if (xfer) begin
        pend_data  <= asm_data;
        pend_fn    <= asm_fn;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= D_IDLE;
      fu_en     <= 1'b0;
      done      <= 1'b0;
      batch_cnt <= '0;
    end else begin
      fu_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        D_IDLE: begin
          if (pend_valid) begin
            state <= D_ISSUE;
            fu_en <= 1'b1;
          end
        end
        D_ISSUE: state <= D_WAIT;
        D_WAIT: begin
          if (fu_valid) begin
            state <= D_IDLE;
            if (batch_cnt == BATCH_LAST) begin
              batch_cnt <= '0;
              done      <= 1'b1;
            end else begin
              batch_cnt <= batch_cnt + 1'b1;
            end
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end

endmodule
